ascii_num_parser: RTL and testbench

Parametrised successor to the single-byte ASCII-to-binary converter. Consumes the receive byte stream from the UART front end (`in`, qualified by `w_RX_dv`). Accumulates a multi-character number in binary, decimal or hexadecimal into a `WIDTH`-bit value and publishes it on a line terminator. Sits between the UART receiver and the ATM command/amount logic. Detects illegal characters, digit-count overrun and arithmetic overflow.

---
 rtl/ascii_num_parser_pkg.sv | 27 ++
 rtl/ascii_digit_decode.sv | 37 +++
 rtl/ascii_num_parser.sv | 131 +++++++++++++
 tb/tb_ascii_num_parser.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_num_parser_pkg.sv
// Shared ASCII constants and enums for the receive-side number and command parsers.
package ascii_pkg;

  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_9   = 8'h39;
  localparam logic [7:0] CHAR_A   = 8'h41;
  localparam logic [7:0] CHAR_F   = 8'h46;
  localparam logic [7:0] CHAR_a   = 8'h61;
  localparam logic [7:0] CHAR_f   = 8'h66;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_ESC = 8'h1B;

  typedef enum logic [1:0] {
    RADIX_BIN = 2'b00,
    RADIX_DEC = 2'b01,
    RADIX_HEX = 2'b10,
    RADIX_RSV = 2'b11
  } radix_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_ERROR = 2'b10
  } parse_state_e;

endpackage

// File: rtl/ascii_digit_decode.sv
// Classifies one ASCII byte as digit / terminator / abort under a given radix.
module ascii_digit_decode
  import ascii_pkg::*;
(
  input  logic [7:0] in,
  input  radix_e     radix,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_abort,
  output logic [3:0] digit
);

  logic num_chr;
  logic upper_chr;
  logic lower_chr;

  always_comb begin
    num_chr   = (in >= CHAR_0) && (in <= CHAR_9);
    upper_chr = (in >= CHAR_A) && (in <= CHAR_F);
    lower_chr = (in >= CHAR_a) && (in <= CHAR_f);
    is_term   = (in == CHAR_CR) || (in == CHAR_LF);
    is_abort  = (in == CHAR_ESC);
    is_digit  = 1'b0;
    digit     = in[3:0];
    case (radix)
      RADIX_BIN: is_digit = (in == CHAR_0) || (in == CHAR_0 + 8'd1);
      RADIX_DEC: is_digit = num_chr;
      RADIX_HEX: begin
        is_digit = num_chr || upper_chr || lower_chr;
        // 'A'/'a' carry 1 in their low nibble, so +9 lands on 10
        if (upper_chr || lower_chr) digit = in[3:0] + 4'd9;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ascii_num_parser.sv
// Accumulates a binary/decimal/hex ASCII number and publishes it on CR/LF,
// rejecting illegal characters, digit overrun and arithmetic overflow.
module ascii_num_parser
  import ascii_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in,
  input  logic                            w_RX_dv,
  input  logic [1:0]                      mode,
  output logic [WIDTH-1:0]                out,
  output logic                            out_valid,
  output logic                            err,
  output logic                            busy,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  parse_state_e     state_q, state_d;
  radix_e           radix_q, radix_d, dec_radix;
  logic [WIDTH-1:0] acc_q, acc_d, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_d, err_d;
  logic             is_digit, is_term, is_abort;
  logic [3:0]       digit;
  logic [WIDTH+3:0] next_val;

  // Shift-only scaling; four guard bits catch any overflow of a single step.
  function automatic logic [WIDTH+3:0] scale(input logic [WIDTH-1:0] a, input radix_e r);
    logic [WIDTH+3:0] ext;
    ext = {4'b0000, a};
    case (r)
      RADIX_BIN: return ext << 1;
      RADIX_HEX: return ext << 4;
      default:   return (ext << 3) + (ext << 1);
    endcase
  endfunction

  // Radix comes from the live mode only while waiting for the first digit.
  assign dec_radix = (state_q == ST_IDLE) ? radix_e'(mode) : radix_q;

  ascii_digit_decode u_decode (
    .in       (in),
    .radix    (dec_radix),
    .is_digit (is_digit),
    .is_term  (is_term),
    .is_abort (is_abort),
    .digit    (digit)
  );

  assign next_val = scale(acc_q, radix_q) + (WIDTH + 4)'(digit);

  always_comb begin
    state_d = state_q;
    radix_d = radix_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    if (w_RX_dv) begin
      case (state_q)
        ST_IDLE: begin
          if (is_digit) begin
            acc_d   = WIDTH'(digit);
            cnt_d   = CNT_W'(1);
            radix_d = radix_e'(mode);
            state_d = ST_ACCUM;
          end else if (!is_term && !is_abort) begin
            state_d = ST_ERROR;
          end
        end
        ST_ACCUM: begin
          if (is_digit) begin
            if ((next_val[WIDTH+3:WIDTH] != 4'd0) || (cnt_q == CNT_W'(MAX_DIGITS))) begin
              state_d = ST_ERROR;
            end else begin
              acc_d = next_val[WIDTH-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term || is_abort) begin
            out_d   = is_term ? acc_q : out;
            ov_d    = is_term;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (is_term || is_abort) begin
            err_d   = is_term;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      radix_q   <= RADIX_DEC;
      acc_q     <= '0;
      cnt_q     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      radix_q   <= radix_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out       <= out_d;
      out_valid <= ov_d;
      err       <= err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_ascii_num_parser.sv
// Bench for ascii_num_parser: directed scenarios plus a randomized stream
// checked against a line-oriented reference model.
module tb_ascii_num_parser;
  localparam int W  = 16;
  localparam int MD = 8;
  localparam int CW = $clog2(MD + 1);
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A, ESC = 8'h1B;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in = 8'h00;
  logic          w_RX_dv = 1'b0;
  logic [1:0]    mode = 2'b01;
  logic [W-1:0]  out;
  logic          out_valid, err, busy;
  logic [CW-1:0] digit_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: one "line" = characters since the last terminator/abort
  bit           m_active = 0;
  bit           m_bad = 0;
  int           m_radix = 1;
  longint       m_val = 0;
  int           m_cnt = 0;
  logic [W-1:0] exp_out = '0;
  bit           exp_ov = 0;
  bit           exp_err = 0;

  ascii_num_parser #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .w_RX_dv   (w_RX_dv),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .err       (err),
    .busy      (busy),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  function automatic int digval(input logic [7:0] c, input int r);
    int v;
    v = -1;
    if (c >= 8'h30 && c <= 8'h39) v = int'(c) - 48;
    else if (c >= 8'h41 && c <= 8'h46) v = int'(c) - 65 + 10;
    else if (c >= 8'h61 && c <= 8'h66) v = int'(c) - 97 + 10;
    case (r)
      0:       return (v == 0 || v == 1) ? v : -1;
      1:       return (v >= 0 && v <= 9) ? v : -1;
      2:       return v;
      default: return -1;
    endcase
  endfunction

  function automatic longint base_of(input int r);
    return (r == 0) ? 2 : (r == 2) ? 16 : 10;
  endfunction

  task automatic model_step(input logic [7:0] c, input logic [1:0] m, input bit dv);
    bit     term, abort;
    int     d;
    longint nv;
    exp_ov  = 0;
    exp_err = 0;
    if (!dv) return;
    term  = (c == CR) || (c == LF);
    abort = (c == ESC);
    if (!m_active) begin
      if (term || abort) return;
      m_active = 1; m_bad = 0; m_radix = int'(m); m_val = 0; m_cnt = 0;
    end
    if (term) begin
      if (m_bad) exp_err = 1;
      else begin exp_ov = 1; exp_out = m_val[W-1:0]; end
      m_active = 0;
    end else if (abort) begin
      m_active = 0;
    end else if (!m_bad) begin
      d = digval(c, m_radix);
      if (d < 0 || m_cnt == MD) m_bad = 1;
      else begin
        nv = m_val * base_of(m_radix) + d;
        if (nv >= (longint'(1) << W)) m_bad = 1;
        else begin m_val = nv; m_cnt++; end
      end
    end
  endtask

  function automatic logic [CW-1:0] exp_cnt();
    return m_active ? CW'(m_cnt) : '0;
  endfunction

  task automatic put(input logic [7:0] c, input logic [1:0] m, input bit dv = 1);
    in = c; mode = m; w_RX_dv = dv;
    @(posedge clk);
    #1;
    model_step(c, m, dv);
    w_RX_dv = 0;
  endtask

  task automatic put_str(input string s, input logic [1:0] m);
    for (int i = 0; i < s.len(); i++) put(s[i], m);
  endtask

  task automatic test_reset;
    #2 rst = 0;
    #1;
    total++;
    if ({out, out_valid, err, busy, digit_cnt} !== '0) begin
      bad++; $display("FAIL reset_async out=%h ov=%b err=%b busy=%b cnt=%0d want all 0", out, out_valid, err, busy, digit_cnt);
    end
    @(posedge clk); #1;
    rst = 1;
    total++;
    if ({out, out_valid, err, busy, digit_cnt} !== '0) begin
      bad++; $display("FAIL reset_hold out=%h ov=%b err=%b busy=%b cnt=%0d want all 0", out, out_valid, err, busy, digit_cnt);
    end
  endtask

  task automatic test_decimal;
    put_str("1234", 2'b01);
    total++;
    if (busy !== 1'b1 || digit_cnt !== CW'(4)) begin
      bad++; $display("FAIL dec_accum busy=%b cnt=%0d want 1/4", busy, digit_cnt);
    end
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b1 || err !== 1'b0 || out !== 16'h04D2) begin
      bad++; $display("FAIL dec_1234 ov=%b err=%b out=%h want 1/0/04d2", out_valid, err, out);
    end
    put(8'h00, 2'b01, 0);
    total++;
    if (out_valid !== 1'b0 || out !== 16'h04D2 || busy !== 1'b0) begin
      bad++; $display("FAIL dec_pulse ov=%b out=%h busy=%b want 0/04d2/0", out_valid, out, busy);
    end
  endtask

  task automatic test_bin_hex;
    put_str("101", 2'b00);
    put(LF, 2'b00);
    total++;
    if (out_valid !== 1'b1 || out !== 16'h0005) begin
      bad++; $display("FAIL bin_101 ov=%b out=%h want 1/0005", out_valid, out);
    end
    put_str("Ff", 2'b10);
    total++;
    if (digit_cnt !== CW'(2) || out_valid !== 1'b0) begin
      bad++; $display("FAIL hex_cnt cnt=%0d ov=%b want 2/0", digit_cnt, out_valid);
    end
    put(CR, 2'b10);
    total++;
    if (out_valid !== 1'b1 || out !== 16'h00FF) begin
      bad++; $display("FAIL hex_ff ov=%b out=%h want 1/00ff", out_valid, out);
    end
  endtask

  task automatic test_overflow;
    put_str("65536", 2'b01);
    put(CR, 2'b01);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b0 || out !== 16'h00FF) begin
      bad++; $display("FAIL ovf_65536 err=%b ov=%b out=%h want 1/0/00ff", err, out_valid, out);
    end
    put(8'h00, 2'b01, 0);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL ovf_pulse err=%b want 0", err);
    end
    put_str("65535", 2'b01);
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b1 || err !== 1'b0 || out !== 16'hFFFF) begin
      bad++; $display("FAIL max_65535 ov=%b err=%b out=%h want 1/0/ffff", out_valid, err, out);
    end
  endtask

  task automatic test_illegal;
    put_str("1x", 2'b01);
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL illegal_busy busy=%b err=%b want 1/0", busy, err);
    end
    put_str("2", 2'b01);
    put(CR, 2'b01);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b0 || out !== 16'hFFFF || busy !== 1'b0) begin
      bad++; $display("FAIL illegal_err err=%b ov=%b out=%h busy=%b want 1/0/ffff/0", err, out_valid, out, busy);
    end
    put_str("7", 2'b01);
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b1 || out !== 16'h0007) begin
      bad++; $display("FAIL illegal_recover ov=%b out=%h want 1/0007", out_valid, out);
    end
  endtask

  task automatic test_abort_latch;
    put_str("1", 2'b10);
    put_str("A", 2'b01);
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b1 || out !== 16'h001A) begin
      bad++; $display("FAIL mode_latch ov=%b out=%h want 1/001a", out_valid, out);
    end
    put_str("9", 2'b01);
    put(ESC, 2'b01);
    total++;
    if (busy !== 1'b0 || digit_cnt !== '0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_clear busy=%b cnt=%0d ov=%b want 0/0/0", busy, digit_cnt, out_valid);
    end
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b0 || err !== 1'b0 || out !== 16'h001A) begin
      bad++; $display("FAIL abort_silent ov=%b err=%b out=%h want 0/0/001a", out_valid, err, out);
    end
  endtask

  task automatic test_overrun;
    put_str("00000001", 2'b00);
    total++;
    if (digit_cnt !== CW'(MD) || busy !== 1'b1) begin
      bad++; $display("FAIL overrun_full cnt=%0d busy=%b want %0d/1", digit_cnt, busy, MD);
    end
    put_str("0", 2'b00);
    put_str("1", 2'b00);
    total++;
    if (digit_cnt !== CW'(MD) || busy !== 1'b1) begin
      bad++; $display("FAIL overrun_frozen cnt=%0d busy=%b want %0d/1", digit_cnt, busy, MD);
    end
    put(LF, 2'b00);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b0 || digit_cnt !== '0) begin
      bad++; $display("FAIL overrun_err err=%b ov=%b cnt=%0d want 1/0/0", err, out_valid, digit_cnt);
    end
    put_str("5", 2'b11);
    put(CR, 2'b11);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reserved_mode err=%b ov=%b want 1/0", err, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    put_str("5", 2'b01);
    put(CR, 2'b01);
    put_str("6", 2'b01);
    total++;
    if (out !== 16'h0005 || busy !== 1'b1 || digit_cnt !== CW'(1)) begin
      bad++; $display("FAIL b2b_start out=%h busy=%b cnt=%0d want 0005/1/1", out, busy, digit_cnt);
    end
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b1 || out !== 16'h0006) begin
      bad++; $display("FAIL b2b_second ov=%b out=%h want 1/0006", out_valid, out);
    end
  endtask

  task automatic test_reset_mid;
    put_str("42", 2'b01);
    #2 rst = 0;
    #1;
    m_active = 0; exp_out = '0; exp_ov = 0; exp_err = 0;
    total++;
    if ({out, out_valid, err, busy, digit_cnt} !== '0) begin
      bad++; $display("FAIL reset_mid out=%h ov=%b err=%b busy=%b cnt=%0d want all 0", out, out_valid, err, busy, digit_cnt);
    end
    #2 rst = 1;
    put(CR, 2'b01);
    total++;
    if (out_valid !== 1'b0 || err !== 1'b0 || out !== '0) begin
      bad++; $display("FAIL reset_cr ov=%b err=%b out=%h want 0/0/0", out_valid, err, out);
    end
  endtask

  task automatic test_random;
    string       digs;
    logic [7:0]  c;
    logic [1:0]  m;
    bit          dv;
    int          r;
    digs = "0123456789ABCDEFabcdef0101";
    m = 2'b01;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) m = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 99);
      dv = 1;
      if (r < 60)      c = digs[$urandom_range(0, digs.len() - 1)];
      else if (r < 70) c = CR;
      else if (r < 76) c = LF;
      else if (r < 81) c = ESC;
      else if (r < 86) c = 8'($urandom_range(0, 255));
      else begin c = 8'($urandom_range(0, 255)); dv = 0; end
      put(c, m, dv);
      total++;
      if (out_valid !== exp_ov || err !== exp_err || out !== exp_out ||
          busy !== m_active || digit_cnt !== exp_cnt()) begin
        bad++;
        $display("FAIL random step=%0d chr=%h dv=%b ov=%b err=%b out=%h busy=%b cnt=%0d want ov=%b err=%b out=%h busy=%b cnt=%0d",
                 i, c, dv, out_valid, err, out, busy, digit_cnt, exp_ov, exp_err, exp_out, m_active, exp_cnt());
      end
    end
  endtask

  initial begin
    test_reset;
    test_decimal;
    test_bin_hex;
    test_overflow;
    test_illegal;
    test_abort_latch;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
